// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: DEPTH-stage scoreboard. It decides stall or issue at ID from a combinational hazard check.
// It also registers the EXE forwarding selects, the stage valid bits and a saturating stall counter.
module hazard_scoreboard #(
    parameter int ADDR_LEN   = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                forward_EN,
    input  logic                ext_stall,
    input  logic                id_valid,
    input  logic [ADDR_LEN-1:0] id_src1,
    input  logic [ADDR_LEN-1:0] id_src2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic [ADDR_LEN-1:0] id_dest,
    input  logic                id_wb_en,
    input  logic                id_mem_r_en,
    output logic                stall,
    output logic [SEL_W-1:0]    exe_sel1,
    output logic [SEL_W-1:0]    exe_sel2,
    output logic [DEPTH-1:0]    stage_valid,
    output logic [CNT_W-1:0]    stall_count
);
    logic [DEPTH-1:0]    valid_q, valid_d, wb_q, wb_d, ld_q, ld_d;
    logic [ADDR_LEN-1:0] dest_q [DEPTH];
    logic [ADDR_LEN-1:0] dest_d [DEPTH];
    logic [SEL_W-1:0]    sel_q [2];
    logic [SEL_W-1:0]    sel_d [2];
    logic [SEL_W-1:0]    hit_k [2];
    logic [ADDR_LEN-1:0] src [2];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          use_op, live, hit, hit_ld, haz;
    logic                hazard;

    assign src[0] = id_src1;
    assign src[1] = id_src2;
    assign use_op = {id_use2, id_use1};

    // Scanning from older to younger stages lets the youngest match overwrite; stage DEPTH is never scanned.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            hit[n] = 1'b0;
            hit_ld[n] = 1'b0;
            hit_k[n] = '0;
            for (int i = DEPTH - 2; i >= 0; i--)
                if (valid_q[i] && wb_q[i] && dest_q[i] == src[n]) begin
                    hit[n] = 1'b1;
                    hit_ld[n] = ld_q[i];
                    hit_k[n] = SEL_W'(i + 1);
                end
            live[n] = use_op[n] && id_valid && (src[n] != '0);
            haz[n] = live[n] && hit[n] && (!forward_EN || (hit_ld[n] && hit_k[n] < SEL_W'(LOAD_STAGE)));
        end
        hazard = |haz;
    end

    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], id_valid && !hazard};
        wb_d = {wb_q[DEPTH-2:0], id_wb_en};
        ld_d = {ld_q[DEPTH-2:0], id_mem_r_en};
        dest_d[0] = id_dest;
        for (int i = 1; i < DEPTH; i++)
            dest_d[i] = dest_q[i-1];
        // The producer moves from stage k to stage k+1 on the same edge the consumer enters EXE.
        for (int n = 0; n < 2; n++)
            sel_d[n] = (!hazard && live[n] && hit[n] && forward_EN) ? hit_k[n] + 1'b1 : '0;
        cnt_d = (hazard && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wb_q <= '0;
            ld_q <= '0;
            dest_q <= '{default: '0};
            sel_q <= '{default: '0};
            cnt_q <= '0;
        end else if (!ext_stall) begin
            valid_q <= valid_d;
            wb_q <= wb_d;
            ld_q <= ld_d;
            dest_q <= dest_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall = !rst && (ext_stall || hazard);
    assign exe_sel1 = sel_q[0];
    assign exe_sel2 = sel_q[1];
    assign stage_valid = valid_q;
    assign stall_count = cnt_q;
endmodule
